// File: rtl/a2d_rr_intf.sv
// Round-robin ADC128S reader: each nxt runs a command word and a read word over a mode-3 SPI link.
// Define A2D_FILT_EN to add a 2-tap averaging filter on each result register.
module a2d_rr_intf #(
    parameter logic [2:0] CH_LFT  = 3'd0,
    parameter logic [2:0] CH_RGHT = 3'd4,
    parameter logic [2:0] CH_BATT = 3'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_GAP,
        ST_READ,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SP_IDLE,
        SP_FRONT,
        SP_XFER,
        SP_PORCH
    } spi_state_t;

    state_t      state_q;
    logic        gap_q;
    logic [1:0]  rr_q;
    logic        busy_q;
    logic        cmplt_q;

    spi_state_t  spi_st_q;
    logic [4:0]  div_q;
    logic [15:0] shreg_q;
    logic        miso_q;
    logic [4:0]  bit_cnt_q;
    logic        ss_n_q;

    logic [2:0]  ch_sel;
    logic [15:0] cmd_word;
    logic        spi_start;
    logic        spi_done;
    logic        wr_en;
    logic [11:0] sample;

    always_comb begin
        ch_sel = CH_BATT;
        case (rr_q)
            2'd0:    ch_sel = CH_LFT;
            2'd1:    ch_sel = CH_RGHT;
            default: ch_sel = CH_BATT;
        endcase
    end

    assign cmd_word  = {2'b00, ch_sel, 11'h000};
    assign spi_start = ((state_q == ST_IDLE) && nxt) || ((state_q == ST_GAP) && gap_q);
    assign spi_done  = (spi_st_q == SP_PORCH);
    assign wr_en     = (state_q == ST_DONE);
    assign sample    = shreg_q[11:0];

    // div parks at 10111 between words, so the start edge is already the first count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_st_q  <= SP_IDLE;
            div_q     <= 5'b10111;
            shreg_q   <= 16'h0000;
            miso_q    <= 1'b0;
            bit_cnt_q <= 5'd0;
            ss_n_q    <= 1'b1;
        end else begin
            case (spi_st_q)
                SP_IDLE: begin
                    if (spi_start) begin
                        ss_n_q    <= 1'b0;
                        div_q     <= 5'b11000;
                        shreg_q   <= cmd_word;
                        bit_cnt_q <= 5'd0;
                        spi_st_q  <= SP_FRONT;
                    end
                end
                SP_FRONT: begin
                    // First SCLK fall carries no shift: MOSI already holds the command MSB.
                    div_q <= div_q + 5'd1;
                    if (div_q == 5'b11111) begin
                        spi_st_q <= SP_XFER;
                    end
                end
                SP_XFER: begin
                    div_q <= div_q + 5'd1;
                    if (div_q == 5'b01111) begin
                        miso_q    <= MISO;
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                    if (div_q == 5'b11111) begin
                        shreg_q <= {shreg_q[14:0], miso_q};
                        if (bit_cnt_q == 5'd16) begin
                            div_q    <= div_q;
                            spi_st_q <= SP_PORCH;
                        end
                    end
                end
                SP_PORCH: begin
                    ss_n_q   <= 1'b1;
                    div_q    <= 5'b10111;
                    spi_st_q <= SP_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= 1'b0;
            rr_q    <= 2'd0;
            busy_q  <= 1'b0;
            cmplt_q <= 1'b0;
        end else begin
            cmplt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (nxt) begin
                        busy_q  <= 1'b1;
                        state_q <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (spi_done) begin
                        gap_q   <= 1'b0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_q <= 1'b1;
                    if (gap_q) begin
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (spi_done) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cmplt_q <= 1'b1;
                    busy_q  <= 1'b0;
                    rr_q    <= (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_res
            logic [11:0] res_q;
            logic [11:0] res_d;
`ifdef A2D_FILT_EN
            logic        valid_q;

            // 13-bit sum keeps the carry; the shift truncates toward zero.
            assign res_d = valid_q ? 12'(({1'b0, res_q} + {1'b0, sample}) >> 1) : sample;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q   <= 12'h000;
                    valid_q <= 1'b0;
                end else if (wr_en && (rr_q == 2'(gi))) begin
                    res_q   <= res_d;
                    valid_q <= 1'b1;
                end
            end
`else
            assign res_d = sample;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q <= 12'h000;
                end else if (wr_en && (rr_q == 2'(gi))) begin
                    res_q <= res_d;
                end
            end
`endif
        end
    endgenerate

    assign lft_ld    = g_res[0].res_q;
    assign rght_ld   = g_res[1].res_q;
    assign batt      = g_res[2].res_q;
    assign cnv_cmplt = cmplt_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign SCLK      = div_q[4];
    assign MOSI      = shreg_q[15];

endmodule

// File: tb/tb_a2d_rr_intf.sv
// Bench for a2d_rr_intf: ADC128S behavioural model, SPI timing monitor and a result model.
// Builds with or without A2D_FILT_EN; the result model follows the same macro.
module tb_a2d_rr_intf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic        cnv_cmplt;
    logic        busy;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    a2d_rr_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .busy      (busy),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // ADC model and SPI monitor (sampled on the falling clk edge)
    typedef struct {
        int          front;
        int          rises;
        int          len;
        int          bad_half;
        int          bad_mosi;
        logic [15:0] word;
    } txn_t;

    txn_t        txn_q[$];
    logic [11:0] adc_val [8];
    logic [15:0] tx_word = 16'hA000;
    bit          in_txn;
    int          t_ss, last_edge, m_rises, m_front, m_bad_half, m_bad_mosi;
    logic [15:0] m_word;
    logic        prev_ss, prev_sclk, prev_mosi;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn = 1'b0;
            MISO   = 1'b0;
        end else begin
            if (prev_ss && !SS_n) begin
                in_txn     = 1'b1;
                t_ss       = cyc;
                last_edge  = cyc;
                m_rises    = 0;
                m_front    = -1;
                m_bad_half = 0;
                m_bad_mosi = 0;
                m_word     = 16'h0000;
                MISO       = tx_word[15];
            end else if (in_txn && !SS_n) begin
                if (prev_sclk && !SCLK) begin
                    if (m_front < 0) m_front = cyc - t_ss;
                    else if (cyc - last_edge != 16) m_bad_half++;
                    last_edge = cyc;
                    if (m_rises < 16) MISO = tx_word[15 - m_rises];
                end
                if (!prev_sclk && SCLK) begin
                    if (cyc - last_edge != 16) m_bad_half++;
                    if (MOSI !== prev_mosi) m_bad_mosi++;
                    last_edge = cyc;
                    m_word    = {m_word[14:0], MOSI};
                    m_rises++;
                end
            end
            if (in_txn && !prev_ss && SS_n) begin
                txn_q.push_back('{m_front, m_rises, cyc - t_ss, m_bad_half, m_bad_mosi, m_word});
                // Data for this command comes back in the next word; top nibble is junk.
                tx_word = {4'hA, adc_val[m_word[13:11]]};
                in_txn  = 1'b0;
            end
        end
        prev_ss   = SS_n;
        prev_sclk = SCLK;
        prev_mosi = MOSI;
    end

    // Result model
    int          chan_of [3] = '{0, 4, 5};
    int          m_rr;
    logic [11:0] m_res [3];
    bit          m_valid [3];

    task automatic model_reset();
        m_rr = 0;
        for (int i = 0; i < 3; i++) begin
            m_res[i]   = 12'h000;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic model_update(input int tgt, input logic [11:0] val);
`ifdef A2D_FILT_EN
        if (m_valid[tgt]) m_res[tgt] = 12'((13'(m_res[tgt]) + 13'(val)) / 2);
        else m_res[tgt] = val;
`else
        m_res[tgt] = val;
`endif
        m_valid[tgt] = 1'b1;
        m_rr = (m_rr + 1) % 3;
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_lft"},  lft_ld,  m_res[0]);
        chk({tag, "_rght"}, rght_ld, m_res[1]);
        chk({tag, "_batt"}, batt,    m_res[2]);
    endtask

    // mode 0: plain; 1: extra nxt 100 clk into CMD; 2: extra nxt in the DONE clk
    task automatic convert(input logic [11:0] val, input int mode, input logic [15:0] exp_cmd);
        int k;
        int n;
        int base;
        int tgt;
        tgt = m_rr;
        adc_val[chan_of[tgt]] = val;
        base = txn_q.size();
        k = cyc;
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        chk("busy_set", busy, 1);
        n = 0;
        while (cnv_cmplt !== 1'b1 && n < 1500) begin
            nxt = (mode == 1 && n == 100) || (mode == 2 && cyc == k + 1044);
            @(negedge clk);
            n++;
        end
        nxt = 1'b0;
        chk("cmplt_seen", cnv_cmplt, 1);
        chk("latency", cyc - (k + 1), 1045);
        model_update(tgt, val);
        check_results("res");
        chk("txn_count", txn_q.size() - base, 2);
        for (int j = 0; j < 2; j++) begin
            if (base + j < txn_q.size()) begin
                chk("front_porch", txn_q[base+j].front, 8);
                chk("rises",       txn_q[base+j].rises, 16);
                chk("txn_len",     txn_q[base+j].len, 521);
                chk("half_period", txn_q[base+j].bad_half, 0);
                chk("mosi_stable", txn_q[base+j].bad_mosi, 0);
                chk("cmd_word",    txn_q[base+j].word, exp_cmd);
            end
        end
        @(negedge clk);
        chk("cmplt_pulse", cnv_cmplt, 0);
        chk("busy_clear", busy, 0);
        $display("conv ch%0d val=%h mode=%0d lft=%h rght=%h batt=%h", chan_of[tgt], val, mode, lft_ld, rght_ld, batt);
    endtask

    typedef struct {
        logic [11:0] val;
        int          mode;
        logic [15:0] exp_cmd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [11:0] rv;
        logic [15:0] ecmd;
        logic [11:0] filt_exp;

        vecs[0] = '{12'hC00, 0, 16'h0000};
        vecs[1] = '{12'h3A5, 0, 16'h2000};
        vecs[2] = '{12'h7FF, 0, 16'h2800};
        vecs[3] = '{12'h123, 1, 16'h0000};
        vecs[4] = '{12'hFFF, 2, 16'h2000};
        vecs[5] = '{12'h801, 0, 16'h2800};

        for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
        model_reset();
        rst_n = 1'b0;
        nxt   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", SS_n, 1);
        chk("rst_sclk", SCLK, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmplt", cnv_cmplt, 0);
        check_results("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) convert(vecs[i].val, vecs[i].mode, vecs[i].exp_cmd);

        // Asynchronous reset in the middle of the READ word
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        repeat (700) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_ss_n", SS_n, 1);
        chk("mid_rst_sclk", SCLK, 1);
        chk("mid_rst_busy", busy, 0);
        model_reset();
        check_results("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset applied mid-READ");
        repeat (3) @(negedge clk);

        // Two lft samples around a full rotation
        convert(12'h800, 0, 16'h0000);
        chk("filt_first", lft_ld, 12'h800);
        convert(12'h111, 0, 16'h2000);
        convert(12'h222, 0, 16'h2800);
        convert(12'h400, 0, 16'h0000);
`ifdef A2D_FILT_EN
        filt_exp = 12'h600;
`else
        filt_exp = 12'h400;
`endif
        chk("filt_second", lft_ld, filt_exp);

        for (int i = 0; i < 10; i++) begin
            rv   = 12'($urandom_range(0, 4095));
            ecmd = {2'b00, 3'(chan_of[m_rr]), 11'h000};
            repeat ($urandom_range(0, 6)) @(negedge clk);
            convert(rv, int'($urandom_range(0, 2)), ecmd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
